// File: rtl/mmu_controller_pkg.sv
// Shared types and constants for the 2x2 systolic matrix-multiply controller.
package mmu_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int CAP_OFF_COL0 = 2;
    localparam int CAP_OFF_COL1 = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } mmu_ctrl_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mmu_controller_if.sv
// Controller-to-mmu bus; the controller is the only master.
interface mmu_controller_if
    import mmu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              load_weight;
    logic              valid;
    logic [DATA_W-1:0] a_in1;
    logic [DATA_W-1:0] a_in2;
    logic [DATA_W-1:0] weight1;
    logic [DATA_W-1:0] weight2;
    logic [DATA_W-1:0] weight3;
    logic [DATA_W-1:0] weight4;
    logic [DATA_W-1:0] acc_out1;
    logic [DATA_W-1:0] acc_out2;

    modport master (
        output load_weight, valid, a_in1, a_in2,
        output weight1, weight2, weight3, weight4,
        input  acc_out1, acc_out2
    );

    modport slave (
        input  load_weight, valid, a_in1, a_in2,
        input  weight1, weight2, weight3, weight4,
        output acc_out1, acc_out2
    );
endinterface

// File: rtl/mmu_controller_skew.sv
// One-stage register with synchronous clear; delays X column 1 by a cycle for the skew.
module mmu_skew_delay #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] q_q;
    logic [DATA_W-1:0] q_d;

    // next value: cleared outside streaming so the first skewed slot is zero
    always_comb begin
        if (clr) begin
            q_d = '0;
        end else begin
            q_d = d;
        end
    end

    // delay register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/mmu_controller.sv
// Sequencer for the 2x2 weight-stationary mmu: latches X/W, streams skewed rows, captures C.
// Optional build macro MMU_CTRL_PERF_EN adds a 16-bit cycle_count output.
module mmu_controller
    import mmu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ROWS   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
`ifdef MMU_CTRL_PERF_EN
    output logic [15:0]                cycle_count,
`endif
    input  logic                       start,
    input  logic [ROWS*2*DATA_W-1:0]   x_mat,
    input  logic [4*DATA_W-1:0]        w_mat,
    output logic                       busy,
    output logic                       done,
    output logic [ROWS*2*DATA_W-1:0]   c_mat,
    mmu_controller_if.master           mmu
);
    localparam int CNT_W = $clog2(ROWS + 3);
    localparam int XW    = ROWS * 2 * DATA_W;

    localparam logic [1:0] ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] ST_LOAD_W = 2'(LOAD_W);
    localparam logic [1:0] ST_STREAM = 2'(STREAM);
    localparam logic [1:0] ST_DONE   = 2'(DONE);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    s_q, s_d;
    logic [XW-1:0]       x_q, x_d;
    logic [XW-1:0]       c_q, c_d;
    logic [4*DATA_W-1:0] w_q, w_d;
    logic                ready_q, ready_d;
    logic                accept_s;
    logic                in_stream_s;
    logic [DATA_W-1:0]   a1_s;
    logic [DATA_W-1:0]   skew_in_s;
    logic [DATA_W-1:0]   skew_out_s;

    // ready_q blocks a start coinciding with the first edge after reset release
    assign ready_d     = 1'b1;
    assign accept_s    = start && ready_q && (state_q == ST_IDLE);
    assign in_stream_s = (state_q == ST_STREAM);

    // FSM, stream counter and operand latches
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        x_d     = x_q;
        w_d     = w_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_LOAD_W;
                    x_d     = x_mat;
                    w_d     = w_mat;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD_W: begin
                state_d = ST_STREAM;
                s_d     = '0;
            end
            ST_STREAM: begin
                if (s_q == CNT_W'(ROWS + 2)) begin
                    state_d = ST_DONE;
                end else begin
                    s_d = s_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // row selection for a_in1 and the skew register input; capture of mmu results
    always_comb begin
        a1_s      = '0;
        skew_in_s = '0;
        c_d       = c_q;
        for (int k = 0; k < ROWS; k++) begin
            a1_s      = (in_stream_s && s_q == CNT_W'(k)) ? x_q[(2*k)*DATA_W +: DATA_W] : a1_s;
            skew_in_s = (in_stream_s && s_q == CNT_W'(k)) ? x_q[(2*k+1)*DATA_W +: DATA_W] : skew_in_s;
            c_d[(2*k)*DATA_W +: DATA_W] = (in_stream_s && s_q == CNT_W'(k + CAP_OFF_COL0))
                                        ? mmu.acc_out1 : c_d[(2*k)*DATA_W +: DATA_W];
            c_d[(2*k+1)*DATA_W +: DATA_W] = (in_stream_s && s_q == CNT_W'(k + CAP_OFF_COL1))
                                          ? mmu.acc_out2 : c_d[(2*k+1)*DATA_W +: DATA_W];
        end
    end

    // state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            x_q     <= '0;
            w_q     <= '0;
            c_q     <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            x_q     <= x_d;
            w_q     <= w_d;
            c_q     <= c_d;
            ready_q <= ready_d;
        end
    end

    mmu_skew_delay #(.DATA_W(DATA_W)) u_skew (
        .clk   (clk),
        .reset (reset),
        .clr   (!in_stream_s),
        .d     (skew_in_s),
        .q     (skew_out_s)
    );

    assign mmu.load_weight = (state_q == ST_LOAD_W);
    assign mmu.valid       = in_stream_s;
    assign mmu.a_in1       = a1_s;
    assign mmu.a_in2       = in_stream_s ? skew_out_s : '0;
    assign mmu.weight1     = w_q[0*DATA_W +: DATA_W];
    assign mmu.weight2     = w_q[1*DATA_W +: DATA_W];
    assign mmu.weight3     = w_q[2*DATA_W +: DATA_W];
    assign mmu.weight4     = w_q[3*DATA_W +: DATA_W];
    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_DONE);
    assign c_mat           = c_q;

`ifdef MMU_CTRL_PERF_EN
    logic [15:0] perf_q, perf_d;

    // the accept cycle counts as 1 so DONE reads ROWS+5; frozen from DONE on
    always_comb begin
        if (accept_s) begin
            perf_d = 16'd1;
        end else if (state_q == ST_LOAD_W || state_q == ST_STREAM) begin
            perf_d = sat_inc16(perf_q);
        end else begin
            perf_d = perf_q;
        end
    end

    // performance counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= 16'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign cycle_count = perf_q;
`endif
endmodule

// File: tb/tb_mmu_controller.sv
// Directed bench for mmu_controller driving a behavioural 2x2 weight-stationary mmu.
module tb_mmu_controller;
    import mmu_pkg::*;

    localparam int DW   = 8;
    localparam int ROWS = 2;
    localparam int XW   = ROWS * 2 * DW;

    typedef struct {
        logic [XW-1:0]   x;
        logic [4*DW-1:0] w;
        logic [XW-1:0]   c;
        bit              poke;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [XW-1:0]   x_mat = '0;
    logic [4*DW-1:0] w_mat = '0;
    logic            busy;
    logic            done;
    logic [XW-1:0]   c_mat;
`ifdef MMU_CTRL_PERF_EN
    logic [15:0]     cycle_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    mmu_controller_if #(.DATA_W(DW)) mmu_bus ();

    mmu_controller #(.DATA_W(DW), .ROWS(ROWS)) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef MMU_CTRL_PERF_EN
        .cycle_count (cycle_count),
`endif
        .start       (start),
        .x_mat       (x_mat),
        .w_mat       (w_mat),
        .busy        (busy),
        .done        (done),
        .c_mat       (c_mat),
        .mmu         (mmu_bus)
    );

    always #5 clk = ~clk;

    // Behavioural mmu: PE[i][j] holds W[i][j]; activations move right, partial sums move down.
    logic [DW-1:0] mw0, mw1, mw2, mw3, a00, a10, ps00, ps01, ps10, ps11;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mw0 <= '0; mw1 <= '0; mw2 <= '0; mw3 <= '0;
            a00 <= '0; a10 <= '0; ps00 <= '0; ps01 <= '0; ps10 <= '0; ps11 <= '0;
        end else begin
            if (mmu_bus.load_weight) begin
                mw0 <= mmu_bus.weight1; mw1 <= mmu_bus.weight2;
                mw2 <= mmu_bus.weight3; mw3 <= mmu_bus.weight4;
            end
            a00  <= mmu_bus.a_in1;
            a10  <= mmu_bus.a_in2;
            ps00 <= mmu_bus.a_in1 * mw0;
            ps01 <= a00 * mw1;
            ps10 <= ps00 + mmu_bus.a_in2 * mw2;
            ps11 <= ps01 + a10 * mw3;
        end
    end
    assign mmu_bus.acc_out1 = ps10;
    assign mmu_bus.acc_out2 = ps11;

    function automatic logic [XW-1:0] mk(input logic [7:0] e00, input logic [7:0] e01,
                                         input logic [7:0] e10, input logic [7:0] e11);
        return {e11, e10, e01, e00};
    endfunction

    function automatic logic [DW-1:0] el(input logic [XW-1:0] m, input int k, input int j);
        return m[(2*k+j)*DW +: DW];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs one operation starting at an IDLE negedge; ends at the first IDLE negedge after DONE.
    task automatic run_op(input vec_t v, input logic [XW-1:0] prev_c);
        logic [DW-1:0] a1e, a2e;
        int s;
        x_mat = v.x; w_mat = v.w; start = 1'b1;
        @(negedge clk);
        start = 1'b0; x_mat = ~v.x; w_mat = ~v.w;
        for (int c = 1; c <= 7; c++) begin
            s   = c - 2;
            a1e = (s >= 0 && s < ROWS)  ? el(v.x, s, 0)     : 8'd0;
            a2e = (s >= 1 && s <= ROWS) ? el(v.x, s - 1, 1) : 8'd0;
            check("ctrl_flags", {busy, done, mmu_bus.load_weight, mmu_bus.valid},
                  {1'b1, (c == 7), (c == 1), (c >= 2 && c <= 6)});
            check("a_in", {mmu_bus.a_in1, mmu_bus.a_in2}, {a1e, a2e});
            check("weights", {mmu_bus.weight4, mmu_bus.weight3, mmu_bus.weight2, mmu_bus.weight1}, v.w);
            if (c == 3) check("c_held_before_capture", c_mat, prev_c);
            if (c == 7) begin
                check("c_result", c_mat, v.c);
`ifdef MMU_CTRL_PERF_EN
                check("cycle_count_done", cycle_count, 64'd7);
`endif
            end
            start = v.poke && (c == 4 || c == 7);
            if (c < 7) @(negedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        check("idle_after_done", {busy, done, mmu_bus.valid, mmu_bus.load_weight}, 64'd0);
        check("c_hold", c_mat, v.c);
`ifdef MMU_CTRL_PERF_EN
        check("cycle_count_hold", cycle_count, 64'd7);
`endif
        if (v.poke) begin
            @(negedge clk);
            check("poke_ignored", {busy, done}, 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[4];
        vecs[0] = '{x: mk(8'd1, 8'd1, 8'd2, 8'd0),   w: mk(8'd1, 8'd2, 8'd3, 8'd4),
                    c: mk(8'd4, 8'd6, 8'd2, 8'd4),   poke: 1'b0};
        vecs[1] = '{x: mk(8'd0, 8'd1, 8'd1, 8'd0),   w: mk(8'd1, 8'd2, 8'd3, 8'd4),
                    c: mk(8'd3, 8'd4, 8'd1, 8'd2),   poke: 1'b0};
        vecs[2] = '{x: mk(8'd1, 8'd1, 8'd2, 8'd0),   w: mk(8'd1, 8'd2, 8'd3, 8'd4),
                    c: mk(8'd4, 8'd6, 8'd2, 8'd4),   poke: 1'b1};
        vecs[3] = '{x: mk(8'd16, 8'd16, 8'd0, 8'd0), w: mk(8'd16, 8'd16, 8'd16, 8'd16),
                    c: mk(8'd0, 8'd0, 8'd0, 8'd0),   poke: 1'b0};

        repeat (2) @(negedge clk);
        check("reset_flags", {busy, done, mmu_bus.load_weight, mmu_bus.valid}, 64'd0);
        check("reset_c", c_mat, 64'd0);
        check("reset_mmu_data", {mmu_bus.a_in1, mmu_bus.a_in2, mmu_bus.weight1, mmu_bus.weight2,
                                 mmu_bus.weight3, mmu_bus.weight4}, 64'd0);
`ifdef MMU_CTRL_PERF_EN
        check("reset_cycle_count", cycle_count, 64'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // vectors 0 and 1 run back to back: second start in the first IDLE cycle after done
        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i], (i == 0) ? '0 : vecs[i-1].c);
        end

        // reset during STREAM at s=2
        x_mat = vecs[0].x; w_mat = vecs[0].w; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_op_valid", mmu_bus.valid, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_flags", {busy, done, mmu_bus.valid, mmu_bus.load_weight}, 64'd0);
        check("rst_mid_c", c_mat, 64'd0);
        check("rst_mid_mmu_data", {mmu_bus.a_in1, mmu_bus.a_in2, mmu_bus.weight1, mmu_bus.weight2,
                                   mmu_bus.weight3, mmu_bus.weight4}, 64'd0);
`ifdef MMU_CTRL_PERF_EN
        check("rst_mid_cycle_count", cycle_count, 64'd0);
`endif
        // start coinciding with reset release must be ignored
        reset = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_at_release_ignored", {busy, mmu_bus.load_weight}, 64'd0);
        run_op(vecs[0], '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
